// File: rtl/ram_dp_clr.sv
// ram_dp_clr: dual-port synchronous RAM with a sequenced whole-array clear.
// Port A reads and writes with byte enables; port B is read-only. After reset,
// or on clr_req, a pointer walks the array writing CLEAR_VAL one word per cycle
// while busy is high. Both read ports have a registered output and a one-cycle
// valid strobe.
//
// Optional feature macro: RAM_DP_CLR_BYPASS_EN
//   defined   - a same-cycle, same-address port A write is forwarded into the
//               port B read result, byte by byte (write-first on port B).
//   undefined - port B is read-first and no forwarding logic is built.

module ram_dp_clr #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       ADDR_W    = 10,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [DATA_W/8-1:0]   a_be,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_din,
    output logic [DATA_W-1:0]     a_dout,
    output logic                  a_valid,

    input  logic                  b_en,
    input  logic [ADDR_W-1:0]     b_addr,
    output logic [DATA_W-1:0]     b_dout,
    output logic                  b_valid,

    input  logic                  clr_req,
    output logic                  busy
);

    localparam int unsigned NB = DATA_W / 8;

    // One extra bit so DEPTH == 2**ADDR_W is representable for the range check.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                run;
    logic                a_rd;
    logic                a_wr;
    logic                b_rd;
    logic                a_in;
    logic                b_in;

    // Replace the bytes of old_w selected by be with the matching bytes of new_w.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(NB); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign busy = (state == S_CLEAR);

    // Access qualification: nothing is accepted while the clear sequencer runs.
    always_comb begin
        run  = (state == S_RUN);
        a_rd = run & a_en & ~a_we;
        a_wr = run & a_en & a_we;
        b_rd = run & b_en;
        a_in = ({1'b0, a_addr} < DEPTH_X);
        b_in = ({1'b0, b_addr} < DEPTH_X);
    end

`ifdef RAM_DP_CLR_BYPASS_EN
    logic fwd;

    // Port B read collides with an in-range port A write to the same word.
    always_comb begin
        fwd = a_wr & a_in & (a_addr == b_addr);
    end
`endif

    // Memory array: clear writes from the sequencer, otherwise byte-masked port A writes.
    // Out-of-range port A writes are dropped.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_CLEAR) begin
                mem[ptr] <= CLEAR_VAL;
            end else if (a_wr && a_in) begin
                for (int i = 0; i < int'(NB); i++) begin
                    if (a_be[i]) begin
                        mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
                    end
                end
            end
        end
    end

    // Clear sequencer and registered read outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            ptr     <= '0;
            a_dout  <= '0;
            b_dout  <= '0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    a_valid <= 1'b0;
                    b_valid <= 1'b0;
                    if (ptr == LAST) begin
                        state <= S_RUN;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                S_RUN: begin
                    a_valid <= a_rd;
                    b_valid <= b_rd;
                    if (a_rd) begin
                        a_dout <= a_in ? mem[a_addr] : '0;
                    end
                    if (b_rd) begin
                        if (!b_in) begin
                            b_dout <= '0;
`ifdef RAM_DP_CLR_BYPASS_EN
                        end else if (fwd) begin
                            b_dout <= merge_bytes(mem[b_addr], a_din, a_be);
`endif
                        end else begin
                            b_dout <= mem[b_addr];
                        end
                    end
                    // This cycle's accesses complete first; the clear starts next edge.
                    if (clr_req) begin
                        state <= S_CLEAR;
                        ptr   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr. A 1024x16 instance (CLEAR_VAL 0) is
// checked every cycle against a behavioural model; a 600x16 instance
// (CLEAR_VAL 0x00A5) is checked with hand-computed literals for the clear
// value and out-of-range behaviour.

module tb_ram_dp_clr;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Instance 0: DEPTH 1024, CLEAR_VAL 0
    logic        a_en = 0, a_we = 0, b_en = 0, clr_req = 0;
    logic [1:0]  a_be = 0;
    logic [9:0]  a_addr = 0, b_addr = 0;
    logic [15:0] a_din = 0;
    logic [15:0] a_dout, b_dout;
    logic        a_valid, b_valid, busy;

    // Instance 1: DEPTH 600, CLEAR_VAL 0x00A5
    logic        c_a_en = 0, c_a_we = 0, c_b_en = 0, c_clr_req = 0;
    logic [1:0]  c_a_be = 0;
    logic [9:0]  c_a_addr = 0, c_b_addr = 0;
    logic [15:0] c_a_din = 0;
    logic [15:0] c_a_dout, c_b_dout;
    logic        c_a_valid, c_b_valid, c_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_dp_clr #(
        .DATA_W(16), .ADDR_W(10), .DEPTH(1024), .CLEAR_VAL(16'h0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout), .a_valid(a_valid),
        .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout), .b_valid(b_valid),
        .clr_req(clr_req), .busy(busy)
    );

    ram_dp_clr #(
        .DATA_W(16), .ADDR_W(10), .DEPTH(600), .CLEAR_VAL(16'h00A5)
    ) dut_small (
        .clk(clk), .rst_n(rst_n),
        .a_en(c_a_en), .a_we(c_a_we), .a_be(c_a_be), .a_addr(c_a_addr), .a_din(c_a_din),
        .a_dout(c_a_dout), .a_valid(c_a_valid),
        .b_en(c_b_en), .b_addr(c_b_addr), .b_dout(c_b_dout), .b_valid(c_b_valid),
        .clr_req(c_clr_req), .busy(c_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of instance 0 ----------------
    logic [15:0] mmem [DEPTH];
    int          left = DEPTH;      // clear edges still to come
    logic [15:0] e_a = 0, e_b = 0;
    logic        e_av = 0, e_bv = 0;

    always @(posedge clk) begin
        logic [15:0] old_a, old_b;
        if (!rst_n) begin
            left = DEPTH;
            e_a = 0; e_b = 0; e_av = 0; e_bv = 0;
        end else if (left > 0) begin
            mmem[DEPTH - left] = 16'h0000;
            left = left - 1;
            e_av = 0; e_bv = 0;
        end else begin
            old_a = mmem[a_addr];
            old_b = mmem[b_addr];
            e_av = a_en && !a_we;
            if (e_av) e_a = old_a;
            e_bv = b_en;
            if (e_bv) begin
                e_b = old_b;
`ifdef RAM_DP_CLR_BYPASS_EN
                if (a_en && a_we && a_addr == b_addr) begin
                    if (a_be[0]) e_b[7:0]  = a_din[7:0];
                    if (a_be[1]) e_b[15:8] = a_din[15:8];
                end
`endif
            end
            if (a_en && a_we) begin
                if (a_be[0]) mmem[a_addr][7:0]  = a_din[7:0];
                if (a_be[1]) mmem[a_addr][15:8] = a_din[15:8];
            end
            if (clr_req) left = DEPTH;
        end
        #1;
        chk("m_busy",    busy,    left > 0);
        chk("m_a_valid", a_valid, e_av);
        chk("m_b_valid", b_valid, e_bv);
        chk("m_a_dout",  a_dout,  e_a);
        chk("m_b_dout",  b_dout,  e_b);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic ae, input logic we, input logic [1:0] be,
                         input logic [9:0] aa, input logic [15:0] ad,
                         input logic ben, input logic [9:0] ba, input logic clr);
        @(negedge clk);
        a_en = ae; a_we = we; a_be = be; a_addr = aa; a_din = ad;
        b_en = ben; b_addr = ba; clr_req = clr;
    endtask

    task automatic idle();
        drive(0, 0, 2'b00, 10'd0, 16'h0, 0, 10'd0, 0);
    endtask

    task automatic c_drive(input logic ae, input logic we, input logic [1:0] be,
                           input logic [9:0] aa, input logic [15:0] ad,
                           input logic ben, input logic [9:0] ba, input logic clr);
        @(negedge clk);
        c_a_en = ae; c_a_we = we; c_a_be = be; c_a_addr = aa; c_a_din = ad;
        c_b_en = ben; c_b_addr = ba; c_clr_req = clr;
    endtask

    // Read one address on both ports of instance 1 and compare to a literal.
    task automatic c_read(input logic [9:0] addr, input logic [15:0] exp, input string nm);
        c_drive(1, 0, 2'b00, addr, 16'h0, 1, addr, 0);
        @(posedge clk); #1;
        chk({nm, "_a_valid"}, c_a_valid, 1'b1);
        chk({nm, "_a_dout"},  c_a_dout,  exp);
        chk({nm, "_b_valid"}, c_b_valid, 1'b1);
        chk({nm, "_b_dout"},  c_b_dout,  exp);
        c_drive(0, 0, 2'b00, 10'd0, 16'h0, 0, 10'd0, 0);
    endtask

    // Count edges until busy drops on instance 0 (bounded).
    task automatic count_busy(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < 3000);
        if (busy) chk("busy_timeout", busy, 1'b0);
    endtask

    task automatic c_count_busy(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (c_busy && n < 3000);
        if (c_busy) chk("c_busy_timeout", c_busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset: 3 cycles low, then release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    busy,    1'b1);
        chk("rst_a_dout",  a_dout,  16'h0);
        chk("rst_b_valid", b_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        chk("reset_busy_edges", n, 1024);
        chk("c_idle_after_reset", c_busy, 1'b0);

        // Every address reads 0 on both ports
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 2'b00, 10'(i), 16'h0, 1, 10'(DEPTH - 1 - i), 0);
        end
        @(posedge clk); #1;
        chk("sweep_last_a", {a_valid, a_dout}, {1'b1, 16'h0000});
        chk("sweep_last_b", {b_valid, b_dout}, {1'b1, 16'h0000});
        idle();

        // Instance 1: clear value, clr_req and out-of-range access
        c_read(10'd599, 16'h00A5, "c_init599");
        c_drive(1, 1, 2'b11, 10'd0,   16'hFFFF, 0, 10'd0, 0);
        c_drive(1, 1, 2'b11, 10'd599, 16'hFFFF, 0, 10'd0, 0);
        c_read(10'd0, 16'hFFFF, "c_loaded0");
        c_drive(0, 0, 2'b00, 10'd0, 16'h0, 0, 10'd0, 1);
        @(posedge clk); #1;
        c_drive(1, 0, 2'b00, 10'd0, 16'h0, 1, 10'd0, 0);
        c_count_busy(n);
        chk("c_clear_edges", n, 600);
        chk("c_no_valid_busy", {c_a_valid, c_b_valid}, 2'b00);
        c_drive(0, 0, 2'b00, 10'd0, 16'h0, 0, 10'd0, 0);
        c_read(10'd0,   16'h00A5, "c_clr0");
        c_read(10'd599, 16'h00A5, "c_clr599");
        c_drive(1, 1, 2'b11, 10'd700, 16'h7777, 0, 10'd0, 0);
        c_read(10'd700, 16'h0000, "c_oob700");
        c_read(10'd599, 16'h00A5, "c_keep599");

        // Byte enables on port A
        drive(1, 1, 2'b11, 10'd5, 16'hABCD, 0, 10'd0, 0);
        drive(1, 1, 2'b01, 10'd5, 16'h1234, 0, 10'd0, 0);
        drive(1, 0, 2'b00, 10'd5, 16'h0, 0, 10'd0, 0);
        @(posedge clk); #1;
        chk("be_a_valid", a_valid, 1'b1);
        chk("be_a_dout",  a_dout,  16'hAB34);
        idle();
        @(posedge clk); #1;
        chk("be_valid_pulse", a_valid, 1'b0);

        // Same-cycle port A write / port B read of addr 9
        drive(1, 1, 2'b11, 10'd9, 16'h5555, 1, 10'd9, 0);
        @(posedge clk); #1;
`ifdef RAM_DP_CLR_BYPASS_EN
        chk("coll_b_dout", b_dout, 16'h5555);
`else
        chk("coll_b_dout", b_dout, 16'h0000);
`endif
        drive(0, 0, 2'b00, 10'd0, 16'h0, 1, 10'd9, 0);
        @(posedge clk); #1;
        chk("coll_next_b", {b_valid, b_dout}, {1'b1, 16'h5555});
        idle();

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] aa, ba;
            aa = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1016, 1023))
                                             : 10'($urandom_range(0, 15));
            ba = ($urandom_range(0, 3) == 0) ? aa : 10'($urandom_range(0, 15));
            drive(1'($urandom), 1'($urandom), 2'($urandom), aa, 16'($urandom),
                  1'($urandom), ba, ($urandom_range(0, 799) == 0));
        end
        idle();
        count_busy(n);

        // clr_req after data is loaded; accesses during busy are ignored
        drive(1, 1, 2'b11, 10'd0,    16'hFFFF, 0, 10'd0, 0);
        drive(1, 1, 2'b11, 10'd1023, 16'hFFFF, 0, 10'd0, 0);
        drive(1, 0, 2'b00, 10'd1023, 16'h0, 1, 10'd0, 0);
        @(posedge clk); #1;
        chk("load_a1023", a_dout, 16'hFFFF);
        chk("load_b0",    b_dout, 16'hFFFF);
        drive(0, 0, 2'b00, 10'd0, 16'h0, 0, 10'd0, 1);
        @(posedge clk); #1;
        n = 0;
        do begin
            drive(1, 1'($urandom), 2'b11, 10'($urandom_range(0, 15)), 16'h9999,
                  1, 10'($urandom_range(0, 15)), 1'($urandom));
            @(posedge clk); #1;
            n++;
        end while (busy && n < 3000);
        chk("clr_busy_edges", n, 1024);
        drive(1, 0, 2'b00, 10'd0, 16'h0, 1, 10'd1023, 0);
        @(posedge clk); #1;
        chk("clr_a0",    {a_valid, a_dout}, {1'b1, 16'h0000});
        chk("clr_b1023", {b_valid, b_dout}, {1'b1, 16'h0000});

        // Mid-clear reset at pointer 500
        drive(1, 0, 2'b00, 10'd5, 16'h0, 1, 10'd9, 1);
        idle();
        repeat (499) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", busy, 1'b1);
        chk("mid_rst_dout", {a_dout, b_dout}, 32'h0);
        chk("mid_rst_valid", {a_valid, b_valid}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        chk("mid_rst_clear_edges", n, 1024);
        drive(1, 0, 2'b00, 10'd5, 16'h0, 1, 10'd9, 0);
        @(posedge clk); #1;
        chk("post_rst_a5", {a_valid, a_dout}, {1'b1, 16'h0000});
        idle();
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
